reset_seq: RTL and testbench

- Reset sequencer directly downstream of the clock/reset generator.
- Consumes the chip-level reset, already synchronised to `clk`, and the DCM-derived system clock.
- Releases resets in a fixed order: bus fabric first, then peripherals, then CPU core. Each stage is separated by a programmable gap.
- Supports a CPU-initiated soft reset and records the cause of the last reset for software.

---
 rtl/reset_seq_pkg.sv | 24 ++
 rtl/reset_seq_timer.sv | 36 +++
 rtl/reset_seq.sv | 152 +++++++++++++++
 tb/tb_reset_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// codes and the active-high reset polarity used by every stage output.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    REL_BUS    = 3'd1,
    REL_PERIPH = 3'd2,
    RUN        = 3'd3,
    SOFT       = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_HW   = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic RESET_DISABLE = 1'b0;

  // Terminal count for a stage lasting 'cycles' edges, sized to the counter.
  function automatic logic [31:0] stage_limit(input int unsigned cycles);
    return 32'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Stage counter for the reset sequencer: counts up every edge unless cleared
// and flags when the count matches the limit selected by the FSM.
module reset_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on request, otherwise advance by one.
  always_comb begin
    if (clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: releases bus, then peripherals, then CPU after programmable
// gaps, supports a CPU soft reset and records the cause of the last reset.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int SOFT_HOLD   = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_rst_req,
  output logic       rst_bus,
  output logic       rst_periph,
  output logic       rst_cpu,
  output logic       sys_ready,
  output logic [1:0] rst_cause
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(stage_limit(HOLD_CYCLES));
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(stage_limit(STAGE_GAP));
  localparam logic [CNT_W-1:0] SOFT_LIM = CNT_W'(stage_limit(SOFT_HOLD));

  state_e     state_q, state_d;
  logic       rst_bus_q, rst_bus_d;
  logic       rst_periph_q, rst_periph_d;
  logic       rst_cpu_q, rst_cpu_d;
  logic       sys_ready_q, sys_ready_d;
  logic [1:0] rst_cause_q, rst_cause_d;

  logic             cnt_clr;
  logic             at_limit;
  logic [CNT_W-1:0] limit_sel;

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .limit    (limit_sel),
    .at_limit (at_limit)
  );

  // Terminal count for the stage currently being timed.
  always_comb begin
    case (state_q)
      HOLD:    limit_sel = HOLD_LIM;
      SOFT:    limit_sel = SOFT_LIM;
      default: limit_sel = GAP_LIM;
    endcase
  end

  // Next-state and output decode; the counter clears on every state change.
  always_comb begin
    state_d      = state_q;
    rst_bus_d    = rst_bus_q;
    rst_periph_d = rst_periph_q;
    rst_cpu_d    = rst_cpu_q;
    sys_ready_d  = sys_ready_q;
    rst_cause_d  = rst_cause_q;
    cnt_clr      = 1'b0;
    case (state_q)
      HOLD: begin
        if (at_limit) begin
          state_d   = REL_BUS;
          rst_bus_d = RESET_DISABLE;
          cnt_clr   = 1'b1;
        end else begin
          cnt_clr = 1'b0;
        end
      end
      REL_BUS: begin
        if (at_limit) begin
          state_d      = REL_PERIPH;
          rst_periph_d = RESET_DISABLE;
          cnt_clr      = 1'b1;
        end else begin
          cnt_clr = 1'b0;
        end
      end
      REL_PERIPH: begin
        if (at_limit) begin
          state_d     = RUN;
          rst_cpu_d   = RESET_DISABLE;
          sys_ready_d = 1'b1;
          cnt_clr     = 1'b1;
        end else begin
          cnt_clr = 1'b0;
        end
      end
      RUN: begin
        // Counter parks at zero while running so SOFT starts from a clean count.
        cnt_clr = 1'b1;
        if (soft_rst_req) begin
          state_d      = SOFT;
          rst_bus_d    = RESET_ENABLE;
          rst_periph_d = RESET_ENABLE;
          rst_cpu_d    = RESET_ENABLE;
          sys_ready_d  = 1'b0;
          rst_cause_d  = CAUSE_SOFT;
        end else begin
          state_d = RUN;
        end
      end
      SOFT: begin
        if (at_limit) begin
          state_d   = REL_BUS;
          rst_bus_d = RESET_DISABLE;
          cnt_clr   = 1'b1;
        end else begin
          cnt_clr = 1'b0;
        end
      end
      default: begin
        state_d      = HOLD;
        rst_bus_d    = RESET_ENABLE;
        rst_periph_d = RESET_ENABLE;
        rst_cpu_d    = RESET_ENABLE;
        sys_ready_d  = 1'b0;
        cnt_clr      = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs; hardware reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HOLD;
      rst_bus_q    <= RESET_ENABLE;
      rst_periph_q <= RESET_ENABLE;
      rst_cpu_q    <= RESET_ENABLE;
      sys_ready_q  <= 1'b0;
      rst_cause_q  <= CAUSE_HW;
    end else begin
      state_q      <= state_d;
      rst_bus_q    <= rst_bus_d;
      rst_periph_q <= rst_periph_d;
      rst_cpu_q    <= rst_cpu_d;
      sys_ready_q  <= sys_ready_d;
      rst_cause_q  <= rst_cause_d;
    end
  end

  assign rst_bus    = rst_bus_q;
  assign rst_periph = rst_periph_q;
  assign rst_cpu    = rst_cpu_q;
  assign sys_ready  = sys_ready_q;
  assign rst_cause  = rst_cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: default-parameter instance plus a 1/1/1
// parameter instance, with release ordering checked on every cycle.
module tb_reset_seq;

  localparam int H = 16;
  localparam int G = 8;
  localparam int S = 32;
  localparam logic [1:0] C_HW   = 2'b01;
  localparam logic [1:0] C_SOFT = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, soft_rst_req;
  logic       rst_bus, rst_periph, rst_cpu, sys_ready;
  logic [1:0] rst_cause;
  logic       sw_reset, sw_soft;
  logic       sw_bus, sw_periph, sw_cpu, sw_ready;
  logic [1:0] sw_cause;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  logic [5:0] exp_q[$];
  logic [5:0] got, exp_v;

  reset_seq #(.HOLD_CYCLES(H), .STAGE_GAP(G), .SOFT_HOLD(S), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
    .rst_bus(rst_bus), .rst_periph(rst_periph), .rst_cpu(rst_cpu),
    .sys_ready(sys_ready), .rst_cause(rst_cause)
  );

  reset_seq #(.HOLD_CYCLES(1), .STAGE_GAP(1), .SOFT_HOLD(1), .CNT_W(8)) u_sweep (
    .clk(clk), .reset(sw_reset), .soft_rst_req(sw_soft),
    .rst_bus(sw_bus), .rst_periph(sw_periph), .rst_cpu(sw_cpu),
    .sys_ready(sw_ready), .rst_cause(sw_cause)
  );

  // Expected {bus, periph, cpu, ready, cause} after edge k of a release
  // that starts its hold stage at edge 1 (k = 0 means still fully in reset).
  function automatic logic [5:0] model(input int k, input int hold, input int gap,
                                       input logic [1:0] cause);
    logic b, p, c;
    b = (k >= hold)           ? 1'b0 : 1'b1;
    p = (k >= hold + gap)     ? 1'b0 : 1'b1;
    c = (k >= hold + 2 * gap) ? 1'b0 : 1'b1;
    return {b, p, c, ~c, cause};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ordering invariants on both instances, every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      n_cmp++;
      if ((!rst_periph && rst_bus) || (!rst_cpu && rst_periph) || (sys_ready !== !rst_cpu)) begin
        n_bad++;
        $display("FAIL invariant_dut got=%b%b%b%b", rst_bus, rst_periph, rst_cpu, sys_ready);
      end
      n_cmp++;
      if ((!sw_periph && sw_bus) || (!sw_cpu && sw_periph) || (sw_ready !== !sw_cpu)) begin
        n_bad++;
        $display("FAIL invariant_sweep got=%b%b%b%b", sw_bus, sw_periph, sw_cpu, sw_ready);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(model(0, H, G, C_HW));
      step();
      mon_on = 1'b1;
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_power_up();
    reset = 1'b0;
    for (int k = 1; k <= H + 2 * G + 3; k++) begin
      exp_q.push_back(model(k, H, G, C_HW));
      step();
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL power_up edge=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_soft_reset();
    for (int j = 0; j <= S + 2 * G + 3; j++) begin
      soft_rst_req = (j == 0);
      exp_q.push_back(model(j, S, G, C_SOFT));
      step();
      soft_rst_req = 1'b0;
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL soft_reset T+%0d got=%b exp=%b", j, got, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    exp_q.push_back(model(0, H, G, C_HW));
    step();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      reset = (k == 20);
      exp_q.push_back((k == 20) ? model(0, H, G, C_HW) : model(k, H, G, C_HW));
    end
    // First pop covers the entry reset, then edges 1..20 with the pulse at 20.
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        reset = (k == 20);
        step();
      end
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL mid_reset edge=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= H + 2 * G + 1; k++) begin
      exp_q.push_back(model(k, H, G, C_HW));
      step();
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL mid_restart edge=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_ignored_req();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= H + 2 * G + 1; k++) begin
      soft_rst_req = (k == 10) || (k == 28);
      exp_q.push_back(model(k, H, G, C_HW));
      step();
      soft_rst_req = 1'b0;
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL ignored_req edge=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    soft_rst_req = 1'b1;
    exp_q.push_back(model(0, H, G, C_HW));
    step();
    reset = 1'b0;
    soft_rst_req = 1'b0;
    got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL simultaneous got=%b exp=%b", got, exp_v);
    end
    for (int k = 1; k <= H + 2 * G + 1; k++) begin
      exp_q.push_back(model(k, H, G, C_HW));
      step();
      got = {rst_bus, rst_periph, rst_cpu, sys_ready, rst_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL simul_release edge=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_sweep();
    sw_reset = 1'b1;
    exp_q.push_back(model(0, 1, 1, C_HW));
    step();
    got = {sw_bus, sw_periph, sw_cpu, sw_ready, sw_cause};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL sweep_reset got=%b exp=%b", got, exp_v);
    end
    sw_reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(model(k, 1, 1, C_HW));
      step();
      got = {sw_bus, sw_periph, sw_cpu, sw_ready, sw_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL sweep_release edge=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
    for (int j = 0; j <= 4; j++) begin
      sw_soft = (j == 0);
      exp_q.push_back(model(j, 1, 1, C_SOFT));
      step();
      sw_soft = 1'b0;
      got = {sw_bus, sw_periph, sw_cpu, sw_ready, sw_cause};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL sweep_soft T+%0d got=%b exp=%b", j, got, exp_v);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    soft_rst_req = 1'b0;
    sw_reset     = 1'b1;
    sw_soft      = 1'b0;
    @(negedge clk);
    test_reset();
    test_power_up();
    test_soft_reset();
    test_mid_reset();
    test_ignored_req();
    test_simultaneous();
    test_sweep();
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
